// File: rtl/sobel_result_reader.sv
// sobel_result_reader
//
// Read-back end of the Sobel output path. Scans the word range
// START_ADDR..END_ADDR of the magnitude and direction SRAMs through one
// shared read address. Each 64-bit word pair is unpacked into eight
// magnitude/direction byte beats on a valid/ready stream. The most
// significant byte (lane 7 of the word) goes out first.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   startEn             start one frame scan (sampled only in IDLE)
//   read_addr           registered word address to both SRAMs
//   mag_q, dir_q        SRAM read data, one clock after read_addr
//   pix_mag, pix_dir    current magnitude/direction pixel
//   pix_valid/ready     pixel stream handshake
//   busy                scan in progress
//   frame_done          one-cycle pulse after the last pixel is accepted
//   pix_sol, pix_eol    start/end-of-row markers (only with the macro)
//
// Optional feature macro: SOBEL_READER_LINE_MARK_EN adds pix_sol/pix_eol.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for startEn
// WAIT   | read_addr presented, SRAM data arrives at the next edge
// CAP    | SRAM data valid, latch both words into the shift registers
// STREAM | emit 8 byte beats, shifting on each accepted beat

module sobel_result_reader #(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned START_ADDR = 768,
    parameter int unsigned END_ADDR   = 65535,
    parameter int unsigned ROW_WORDS  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              startEn,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [63:0]       mag_q,
    input  logic [63:0]       dir_q,
    output logic [7:0]        pix_mag,
    output logic [7:0]        pix_dir,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              frame_done
`ifdef SOBEL_READER_LINE_MARK_EN
    ,
    output logic              pix_sol,
    output logic              pix_eol
`endif
);

    if (END_ADDR < START_ADDR) begin : g_bad_range
        $error("sobel_result_reader: END_ADDR must be >= START_ADDR");
    end
    if (ROW_WORDS == 0 || ROW_WORDS > 256 || (ROW_WORDS & (ROW_WORDS - 1)) != 0) begin : g_bad_row
        $error("sobel_result_reader: ROW_WORDS must be a power of two <= 256");
    end

    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        CAP    = 2'd2,
        STREAM = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] word_addr, word_addr_n;
    logic [ADDR_W-1:0] read_addr_n;
    logic [2:0]        lane, lane_n;
    logic [63:0]       mag_sh, mag_sh_n;
    logic [63:0]       dir_sh, dir_sh_n;
    logic              pix_valid_n;
    logic              busy_n;
    logic              frame_done_n;

`ifdef SOBEL_READER_LINE_MARK_EN
    localparam logic [ADDR_W-1:0] ROW_MASK = ADDR_W'(ROW_WORDS - 1);
    logic [ADDR_W-1:0] row_pos;
    logic              pix_sol_n;
    logic              pix_eol_n;

    assign row_pos = word_addr & ROW_MASK;
`endif

    // The shift registers clear on reset and empty out after eight shifts,
    // so the pixel outputs read straight from their top byte.
    assign pix_mag = mag_sh[63:56];
    assign pix_dir = dir_sh[63:56];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            word_addr  <= START_A;
            read_addr  <= '0;
            lane       <= '0;
            mag_sh     <= '0;
            dir_sh     <= '0;
            pix_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef SOBEL_READER_LINE_MARK_EN
            pix_sol    <= 1'b0;
            pix_eol    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            word_addr  <= word_addr_n;
            read_addr  <= read_addr_n;
            lane       <= lane_n;
            mag_sh     <= mag_sh_n;
            dir_sh     <= dir_sh_n;
            pix_valid  <= pix_valid_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
`ifdef SOBEL_READER_LINE_MARK_EN
            pix_sol    <= pix_sol_n;
            pix_eol    <= pix_eol_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        word_addr_n  = word_addr;
        read_addr_n  = read_addr;
        lane_n       = lane;
        mag_sh_n     = mag_sh;
        dir_sh_n     = dir_sh;
        pix_valid_n  = pix_valid;
        busy_n       = busy;
        frame_done_n = 1'b0;
`ifdef SOBEL_READER_LINE_MARK_EN
        pix_sol_n    = pix_sol;
        pix_eol_n    = pix_eol;
`endif

        case (state)
            IDLE: begin
                if (startEn) begin
                    read_addr_n = START_A;
                    word_addr_n = START_A;
                    busy_n      = 1'b1;
                    state_n     = WAIT;
                end
            end

            WAIT: begin
                state_n = CAP;
            end

            CAP: begin
                mag_sh_n    = mag_q;
                dir_sh_n    = dir_q;
                lane_n      = 3'd0;
                pix_valid_n = 1'b1;
                state_n     = STREAM;
`ifdef SOBEL_READER_LINE_MARK_EN
                pix_sol_n   = (row_pos == '0);
                pix_eol_n   = 1'b0;
`endif
            end

            STREAM: begin
                // pix_valid is always high here, so ready alone is the handshake.
                if (pix_ready) begin
                    mag_sh_n = {mag_sh[55:0], 8'h00};
                    dir_sh_n = {dir_sh[55:0], 8'h00};
                    lane_n   = lane + 3'd1;
`ifdef SOBEL_READER_LINE_MARK_EN
                    pix_sol_n = 1'b0;
                    pix_eol_n = (row_pos == ROW_MASK) && (lane == 3'd6);
`endif
                    if (lane == 3'd7) begin
                        pix_valid_n = 1'b0;
`ifdef SOBEL_READER_LINE_MARK_EN
                        pix_eol_n   = 1'b0;
`endif
                        if (word_addr == END_A) begin
                            frame_done_n = 1'b1;
                            busy_n       = 1'b0;
                            state_n      = IDLE;
                        end else begin
                            word_addr_n = word_addr + ADDR_W'(1);
                            read_addr_n = word_addr + ADDR_W'(1);
                            state_n     = WAIT;
                        end
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sobel_result_reader.sv
`timescale 1ns/1ps
module tb_sobel_result_reader;

    localparam int AW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic ready;
    int   sel;
    int   n_vec = 0;
    int   n_err = 0;

    // instance A: single word 768..768
    logic [AW-1:0] a_addr;
    logic [63:0]   a_mq, a_dq;
    logic [7:0]    a_mag, a_dir;
    logic          a_valid, a_busy, a_done, a_start;
    // instance B: three words 768..770
    logic [AW-1:0] b_addr;
    logic [63:0]   b_mq, b_dq;
    logic [7:0]    b_mag, b_dir;
    logic          b_valid, b_busy, b_done, b_start;
`ifdef SOBEL_READER_LINE_MARK_EN
    logic          a_sol, a_eol, b_sol, b_eol;
    // instance C: row boundary 1023..1024
    logic [AW-1:0] c_addr;
    logic [63:0]   c_mq, c_dq;
    logic [7:0]    c_mag, c_dir;
    logic          c_valid, c_busy, c_done, c_start, c_sol, c_eol;
`endif

    logic [AW-1:0] o_addr;
    logic [7:0]    o_mag, o_dir;
    logic          o_valid, o_busy, o_done, o_sol, o_eol;

    assign a_start = start && (sel == 0);
    assign b_start = start && (sel == 1);

    sobel_result_reader #(.ADDR_W(AW), .START_ADDR(768), .END_ADDR(768), .ROW_WORDS(256)) u_a (
        .clk(clk), .reset(reset), .startEn(a_start), .read_addr(a_addr),
        .mag_q(a_mq), .dir_q(a_dq), .pix_mag(a_mag), .pix_dir(a_dir),
        .pix_valid(a_valid), .pix_ready(ready), .busy(a_busy), .frame_done(a_done)
`ifdef SOBEL_READER_LINE_MARK_EN
        , .pix_sol(a_sol), .pix_eol(a_eol)
`endif
    );

    sobel_result_reader #(.ADDR_W(AW), .START_ADDR(768), .END_ADDR(770), .ROW_WORDS(256)) u_b (
        .clk(clk), .reset(reset), .startEn(b_start), .read_addr(b_addr),
        .mag_q(b_mq), .dir_q(b_dq), .pix_mag(b_mag), .pix_dir(b_dir),
        .pix_valid(b_valid), .pix_ready(ready), .busy(b_busy), .frame_done(b_done)
`ifdef SOBEL_READER_LINE_MARK_EN
        , .pix_sol(b_sol), .pix_eol(b_eol)
`endif
    );

`ifdef SOBEL_READER_LINE_MARK_EN
    assign c_start = start && (sel == 2);

    sobel_result_reader #(.ADDR_W(AW), .START_ADDR(1023), .END_ADDR(1024), .ROW_WORDS(256)) u_c (
        .clk(clk), .reset(reset), .startEn(c_start), .read_addr(c_addr),
        .mag_q(c_mq), .dir_q(c_dq), .pix_mag(c_mag), .pix_dir(c_dir),
        .pix_valid(c_valid), .pix_ready(ready), .busy(c_busy), .frame_done(c_done),
        .pix_sol(c_sol), .pix_eol(c_eol)
    );
`endif

    function automatic logic [63:0] mag_word(input logic [AW-1:0] a);
        case (a)
            20'd768:  return 64'hF0E0D0C0B0A09080;
            20'd769:  return 64'h1122334455667788;
            20'd770:  return 64'h99AABBCCDDEEFF00;
            20'd1023: return 64'h0F1E2D3C4B5A6978;
            20'd1024: return 64'h8796A5B4C3D2E1F0;
            default:  return 64'hDEADBEEFDEADBEEF;
        endcase
    endfunction

    function automatic logic [63:0] dir_word(input logic [AW-1:0] a);
        case (a)
            20'd768:  return 64'h0102030405060708;
            20'd769:  return 64'h090A0B0C0D0E0F10;
            20'd770:  return 64'h1112131415161718;
            20'd1023: return 64'h2122232425262728;
            20'd1024: return 64'h3132333435363738;
            default:  return 64'h0;
        endcase
    endfunction

    // one-cycle-latency SRAM models
    always @(posedge clk) begin
        a_mq <= mag_word(a_addr);
        a_dq <= dir_word(a_addr);
        b_mq <= mag_word(b_addr);
        b_dq <= dir_word(b_addr);
`ifdef SOBEL_READER_LINE_MARK_EN
        c_mq <= mag_word(c_addr);
        c_dq <= dir_word(c_addr);
`endif
    end

    always_comb begin
        o_addr  = a_addr;
        o_mag   = a_mag;
        o_dir   = a_dir;
        o_valid = a_valid;
        o_busy  = a_busy;
        o_done  = a_done;
        o_sol   = 1'b0;
        o_eol   = 1'b0;
        if (sel == 1) begin
            o_addr  = b_addr;
            o_mag   = b_mag;
            o_dir   = b_dir;
            o_valid = b_valid;
            o_busy  = b_busy;
            o_done  = b_done;
        end
`ifdef SOBEL_READER_LINE_MARK_EN
        if (sel == 2) begin
            o_addr  = c_addr;
            o_mag   = c_mag;
            o_dir   = c_dir;
            o_valid = c_valid;
            o_busy  = c_busy;
            o_done  = c_done;
            o_sol   = c_sol;
            o_eol   = c_eol;
        end
`endif
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic begin_scan(input bit preset, input logic [AW-1:0] first);
        if (!preset) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        chk("start_addr", 64'(o_addr), 64'(first));
        chk("start_busy", 64'(o_busy), 64'd1);
        chk("start_valid", 64'(o_valid), 64'd0);
        @(negedge clk);
        chk("wait_valid", 64'(o_valid), 64'd0);
    endtask

    task automatic finish_scan(input bit restart);
        @(negedge clk);
        chk("done_pulse", 64'(o_done), 64'd1);
        chk("done_busy", 64'(o_busy), 64'd0);
        chk("done_valid", 64'(o_valid), 64'd0);
        if (restart) begin
            start = 1'b1;
        end else begin
            @(negedge clk);
            chk("done_clear", 64'(o_done), 64'd0);
        end
    endtask

    // pat 0: ready always high; pat 1: ready 1,0,0,1,0 repeating.
    task automatic scan(input int nwords, input int pat, input int pulse_at, input int abort_at);
        int            beats = 0;
        int            gap = 0;
        int            cyc = 0;
        int            fd = 0;
        int            lane;
        bit            stalled = 1'b0;
        logic [7:0]    pm = '0;
        logic [7:0]    pd = '0;
        logic [AW-1:0] base, w;
        logic [63:0]   ew, ed;
        base = (sel == 2) ? AW'(1023) : AW'(768);
        while (beats < nwords * 8 && cyc < 400) begin
            @(negedge clk);
            ready = (pat == 0) ? 1'b1 : ((cyc % 5 == 0) || (cyc % 5 == 3));
            start = (cyc == pulse_at);
            if (beats == abort_at) begin
                start = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                chk("abort_valid", 64'(o_valid), 64'd0);
                chk("abort_busy", 64'(o_busy), 64'd0);
                chk("abort_addr", 64'(o_addr), 64'd0);
                reset = 1'b0;
                return;
            end
            if (cyc == 0) chk("first_valid", 64'(o_valid), 64'd1);
            if (o_done) fd++;
            if (stalled) begin
                chk("hold_valid", 64'(o_valid), 64'd1);
                chk("hold_mag", 64'(o_mag), 64'(pm));
                chk("hold_dir", 64'(o_dir), 64'(pd));
            end
            stalled = 1'b0;
            if (o_valid) begin
                if (beats > 0 && beats % 8 == 0 && pat == 0) chk("gap", 64'(gap), 64'd2);
                gap  = 0;
                w    = base + AW'(beats / 8);
                lane = beats % 8;
                ew   = mag_word(w);
                ed   = dir_word(w);
                chk("addr", 64'(o_addr), 64'(w));
                chk("mag", 64'(o_mag), 64'(8'(ew >> (56 - 8 * lane))));
                chk("dir", 64'(o_dir), 64'(8'(ed >> (56 - 8 * lane))));
`ifdef SOBEL_READER_LINE_MARK_EN
                if (sel == 2) begin
                    chk("sol", 64'(o_sol), 64'(lane == 0 && w == 1024));
                    chk("eol", 64'(o_eol), 64'(lane == 7 && w == 1023));
                end
`endif
                if (ready) begin
                    beats++;
                end else begin
                    stalled = 1'b1;
                    pm = o_mag;
                    pd = o_dir;
                end
            end else begin
                gap++;
            end
            cyc++;
        end
        start = 1'b0;
        chk("beats", 64'(beats), 64'(nwords * 8));
        chk("early_done", 64'(fd), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        sel   = 0;
        repeat (3) @(negedge clk);
        chk("rst_addr", 64'(a_addr), 64'd0);
        chk("rst_mag", 64'(a_mag), 64'd0);
        chk("rst_dir", 64'(a_dir), 64'd0);
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        chk("rst_b_busy", 64'(b_busy), 64'd0);
        reset = 1'b0;

        // single word, ready high, restart in the frame_done cycle
        sel = 0;
        begin_scan(1'b0, AW'(768));
        scan(1, 0, -1, -1);
        finish_scan(1'b1);
        // same word under backpressure
        begin_scan(1'b1, AW'(768));
        scan(1, 1, -1, -1);
        finish_scan(1'b0);

        // three words, startEn pulsed mid-scan
        sel = 1;
        begin_scan(1'b0, AW'(768));
        scan(3, 0, 10, -1);
        finish_scan(1'b0);

        // reset at beat 4 of word 769, then a clean rescan
        begin_scan(1'b0, AW'(768));
        scan(3, 0, -1, 12);
        begin_scan(1'b0, AW'(768));
        scan(3, 0, -1, -1);
        finish_scan(1'b0);

`ifdef SOBEL_READER_LINE_MARK_EN
        sel = 2;
        begin_scan(1'b0, AW'(1023));
        scan(2, 0, -1, -1);
        finish_scan(1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
